// File: rtl/uart_echo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_echo_pkg : shared state encodings and framing constants       |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
package uart_echo_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // RX and TX share the package scope, so literals carry an RX_/TX_ prefix.
  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_IDLE = 3'd4
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_baud_tick : one-clk enable every CLK_DIV cycles (oversample)  |
// | Revision       : 1.0                                               |
// +--------------------------------------------------------------------+
module uart_baud_tick #(
  parameter int CLK_DIV = 54
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int            CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_echo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_echo : 8N1 UART receiver looped back into a transmitter       |
// | Option    : UART_RX_SYNC_EN adds a 2-flop synchronizer on RsRx     |
// | Revision  : 1.0                                                    |
// +--------------------------------------------------------------------+
module uart_echo
  import uart_echo_pkg::*;
#(
  parameter int CLK_DIV  = 54,
  parameter int OVERSAMP = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic RsRx,
  output logic RsTx,
  output logic frame_err
);

  localparam int               CNT_W    = $clog2(OVERSAMP);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMP / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMP - 1);
  localparam int               BIT_W    = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  logic tick;

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  logic rx_in;
`ifdef UART_RX_SYNC_EN
  logic rx_meta;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_in   <= 1'b1;
    end else begin
      rx_meta <= RsRx;
      rx_in   <= rx_meta;
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rx_in <= 1'b1;
    else          rx_in <= RsRx;
  end
`endif

  rx_state_t            rx_state, rx_state_nxt;
  logic [CNT_W-1:0]     rx_cnt, rx_cnt_nxt;
  logic [BIT_W-1:0]     rx_bit, rx_bit_nxt;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_nxt;
  logic                 rx_done, rx_bad;

  // Count restarts at mid-start, so every later 16-tick boundary is mid-bit.
  always_comb begin
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = rx_cnt;
    rx_bit_nxt   = rx_bit;
    rx_shift_nxt = rx_shift;
    rx_done      = 1'b0;
    rx_bad       = 1'b0;
    if (tick) begin
      rx_cnt_nxt = rx_cnt + 1'b1;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt_nxt = '0;
          if (rx_in == START_BIT) rx_state_nxt = RX_START;
        end
        RX_START: begin
          if (rx_cnt == CNT_MID) begin
            rx_cnt_nxt   = '0;
            rx_bit_nxt   = '0;
            rx_state_nxt = (rx_in == START_BIT) ? RX_DATA : RX_IDLE;
          end
        end
        RX_DATA: begin
          if (rx_cnt == CNT_LAST) begin
            rx_cnt_nxt   = '0;
            rx_shift_nxt = {rx_in, rx_shift[DATA_BITS-1:1]};
            if (rx_bit == BIT_LAST) rx_state_nxt = RX_STOP;
            else                    rx_bit_nxt   = rx_bit + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == CNT_LAST) begin
            rx_cnt_nxt = '0;
            if (rx_in == STOP_BIT) begin
              rx_done      = 1'b1;
              rx_state_nxt = RX_IDLE;
            end else begin
              rx_bad       = 1'b1;
              rx_state_nxt = RX_WAIT_IDLE;
            end
          end
        end
        RX_WAIT_IDLE: begin
          rx_cnt_nxt = '0;
          if (rx_in == STOP_BIT) rx_state_nxt = RX_IDLE;
        end
        default: rx_state_nxt = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_nxt;
      rx_cnt   <= rx_cnt_nxt;
      rx_bit   <= rx_bit_nxt;
      rx_shift <= rx_shift_nxt;
    end
  end

  tx_state_t            tx_state, tx_state_nxt;
  logic                 valid, ready, xfer;
  logic [DATA_BITS-1:0] data;

  assign ready = (tx_state == TX_IDLE);
  assign xfer  = valid & ready;

  // A byte completing while valid is still set overwrites the pending one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid     <= 1'b0;
      data      <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= rx_bad;
      if (rx_done) begin
        data  <= rx_shift_nxt;
        valid <= 1'b1;
      end else if (xfer) begin
        valid <= 1'b0;
      end
    end
  end

  logic [CNT_W-1:0]     tx_cnt, tx_cnt_nxt;
  logic [BIT_W-1:0]     tx_bit, tx_bit_nxt;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_nxt;
  logic                 tx_armed, tx_armed_nxt;
  logic                 tx_out_nxt;

  // tx_armed marks that the start bit is on the line; before that, START waits for a tick.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_cnt;
    tx_bit_nxt   = tx_bit;
    tx_shift_nxt = tx_shift;
    tx_armed_nxt = tx_armed;
    tx_out_nxt   = RsTx;
    case (tx_state)
      TX_IDLE: begin
        tx_out_nxt = STOP_BIT;
        if (xfer) begin
          tx_state_nxt = TX_START;
          tx_shift_nxt = data;
          tx_armed_nxt = 1'b0;
        end
      end
      TX_START: begin
        if (tick) begin
          if (!tx_armed) begin
            tx_armed_nxt = 1'b1;
            tx_cnt_nxt   = '0;
            tx_out_nxt   = START_BIT;
          end else if (tx_cnt == CNT_LAST) begin
            tx_cnt_nxt   = '0;
            tx_bit_nxt   = '0;
            tx_out_nxt   = tx_shift[0];
            tx_state_nxt = TX_DATA;
          end else begin
            tx_cnt_nxt = tx_cnt + 1'b1;
          end
        end
      end
      TX_DATA: begin
        if (tick) begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt_nxt = '0;
            if (tx_bit == BIT_LAST) begin
              tx_out_nxt   = STOP_BIT;
              tx_state_nxt = TX_STOP;
            end else begin
              tx_bit_nxt   = tx_bit + 1'b1;
              tx_shift_nxt = tx_shift >> 1;
              tx_out_nxt   = tx_shift[1];
            end
          end else begin
            tx_cnt_nxt = tx_cnt + 1'b1;
          end
        end
      end
      TX_STOP: begin
        if (tick) begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt_nxt   = '0;
            tx_armed_nxt = 1'b0;
            tx_state_nxt = TX_IDLE;
          end else begin
            tx_cnt_nxt = tx_cnt + 1'b1;
          end
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_armed <= 1'b0;
      RsTx     <= 1'b1;
    end else begin
      tx_state <= tx_state_nxt;
      tx_cnt   <= tx_cnt_nxt;
      tx_bit   <= tx_bit_nxt;
      tx_shift <= tx_shift_nxt;
      tx_armed <= tx_armed_nxt;
      RsTx     <= tx_out_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_echo.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | tb_uart_echo : directed vectors and frame-level checks for uart_echo|
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
module tb_uart_echo;

  // Shortened divider keeps frames short; every bit timing below scales from BIT_NS.
  localparam int CLK_DIV  = 8;
  localparam int OVERSAMP = 16;
  localparam int BIT_NS   = OVERSAMP * CLK_DIV * 10;

  logic clk = 1'b0;
  logic reset_n;
  logic RsRx;
  logic RsTx;
  logic frame_err;

  uart_echo #(.CLK_DIV(CLK_DIV), .OVERSAMP(OVERSAMP)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .RsRx      (RsRx),
    .RsTx      (RsTx),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int ferr_cnt = 0;
  int mon_bad_stop = 0;
  logic [7:0] q[$];

  always @(posedge clk) if (frame_err) ferr_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int bit_ns, input bit stop_ok);
    RsRx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      RsRx = b[i];
      #(bit_ns);
    end
    RsRx = stop_ok;
    #(bit_ns);
    RsRx = 1'b1;
  endtask

  task automatic wait_q(input int n, input int max_ns, output bit ok);
    int t = 0;
    while (q.size() < n && t < max_ns) begin
      #100;
      t += 100;
    end
    ok = (q.size() >= n);
  endtask

  // Line monitor: decodes RsTx at nominal rate; frames cut by reset are dropped.
  initial begin
    logic [7:0] mb;
    bit aborted;
    forever begin
      @(negedge RsTx);
      if (reset_n) begin
        aborted = 1'b0;
        #(BIT_NS / 2 + 2);
        if (RsTx == 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            #(BIT_NS);
            mb[i] = RsTx;
            if (!reset_n) aborted = 1'b1;
          end
          #(BIT_NS);
          if (!reset_n) aborted = 1'b1;
          if (!aborted) begin
            if (RsTx) q.push_back(mb);
            else      mon_bad_stop++;
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] b;
    int         pct;
    bit         stop_ok;
    bit         echo;
    int         ferr;
  } vec_t;

  vec_t vecs[9];

  initial begin
    bit ok;
    bit bad;
    int f0;
    realtime t0, t1, t2, t3;
    logic [7:0] rb;

    vecs[0] = '{8'h48, 102, 1'b1, 1'b1, 0};
    vecs[1] = '{8'h65, 102, 1'b1, 1'b1, 0};
    vecs[2] = '{8'h6C, 102, 1'b1, 1'b1, 0};
    vecs[3] = '{8'h6C, 102, 1'b1, 1'b1, 0};
    vecs[4] = '{8'h6F, 102, 1'b1, 1'b1, 0};
    vecs[5] = '{8'h00,  97, 1'b1, 1'b1, 0};
    vecs[6] = '{8'hFF, 103, 1'b1, 1'b1, 0};
    vecs[7] = '{8'hA5, 100, 1'b0, 1'b0, 1};
    vecs[8] = '{8'h3C, 100, 1'b1, 1'b1, 0};

    reset_n = 1'b1;
    RsRx    = 1'b1;
    #1 reset_n = 1'b0;
    bad = 1'b0;
    repeat (55) begin
      #100;
      if (RsTx !== 1'b1 || frame_err !== 1'b0) bad = 1'b1;
    end
    check("reset_hold_idle", 32'(bad), 0);
    @(negedge clk) reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_reset_rstx", 32'(RsTx), 1);
    check("post_reset_ferr", 32'(frame_err), 0);

    foreach (vecs[i]) begin
      #($urandom_range(0, BIT_NS * 58 / 100));
      f0 = ferr_cnt;
      q.delete();
      send_byte(vecs[i].b, BIT_NS * vecs[i].pct / 100, vecs[i].stop_ok);
      if (vecs[i].echo) begin
        wait_q(1, 30 * BIT_NS, ok);
        check($sformatf("echo_seen[%0d]", i), 32'(ok), 1);
        if (ok) check($sformatf("echo_byte[%0d]", i), 32'(q.pop_front()), 32'(vecs[i].b));
      end else begin
        #(25 * BIT_NS);
        check($sformatf("no_echo[%0d]", i), q.size(), 0);
      end
      check($sformatf("frame_err_count[%0d]", i), ferr_cnt - f0, vecs[i].ferr);
    end

    q.delete();
    fork
      begin
        send_byte(8'h55, BIT_NS, 1'b1);
        send_byte(8'hAA, BIT_NS, 1'b1);
      end
      begin
        @(negedge RsTx); t0 = $realtime;
        @(posedge RsTx); t1 = $realtime;
        wait (q.size() >= 1);
        @(negedge RsTx); t2 = $realtime;
        @(posedge RsTx); t3 = $realtime;
      end
    join
    check("b2b_55_start_bit_ns", int'(t1 - t0), BIT_NS);
    check("b2b_AA_two_bits_ns", int'(t3 - t2), 2 * BIT_NS);
    wait_q(2, 30 * BIT_NS, ok);
    check("b2b_both_seen", 32'(ok), 1);
    if (ok) begin
      check("b2b_first", 32'(q.pop_front()), 32'h55);
      check("b2b_second", 32'(q.pop_front()), 32'hAA);
    end

    q.delete();
    f0 = ferr_cnt;
    RsRx = 1'b0;
    #(BIT_NS * 23 / 100);
    RsRx = 1'b1;
    #(25 * BIT_NS);
    check("glitch_no_echo", q.size(), 0);
    check("glitch_no_ferr", ferr_cnt - f0, 0);

    // Reset during 0xFF data bits, then during the start bit of a 0x00 echo.
    for (int k = 0; k < 2; k++) begin
      q.delete();
      rb = (k == 0) ? 8'hFF : 8'h00;
      fork
        send_byte(rb, BIT_NS, 1'b1);
      join_none
      @(negedge RsTx);
      #((k == 0) ? (3 * BIT_NS + BIT_NS / 4 + 3) : (BIT_NS / 4 + 3));
      reset_n = 1'b0;
      #1;
      check($sformatf("rst_rstx_high[%0d]", k), 32'(RsTx), 1);
      #(3 * BIT_NS);
      @(negedge clk) reset_n = 1'b1;
      #(2 * BIT_NS);
      send_byte(8'h5A, BIT_NS, 1'b1);
      wait_q(1, 30 * BIT_NS, ok);
      check($sformatf("rst_next_seen[%0d]", k), 32'(ok), 1);
      if (ok) check($sformatf("rst_next_byte[%0d]", k), 32'(q.pop_front()), 32'h5A);
    end

    check("monitor_stop_bits", mon_bad_stop, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
